// File: rtl/pipe_stage_chain.sv
// Elastic chain of STAGES register slots. Slots advance on a valid/ready
// handshake, empty slots collapse, and a youngest-first forwarding lookup is provided.
module pipe_stage_chain #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned STAGES = 4
) (
  input  logic                     Clk,
  input  logic                     Clr,
  input  logic                     In_valid,
  output logic                     In_ready,
  input  logic [DATA_W-1:0]        In_data,
  input  logic [TAG_W-1:0]         In_tag,
  input  logic                     In_wen,
  output logic                     Out_valid,
  input  logic                     Out_ready,
  output logic [DATA_W-1:0]        Out_data,
  output logic [TAG_W-1:0]         Out_tag,
  output logic                     Out_wen,
  input  logic                     Flush,
  input  logic [TAG_W-1:0]         Q_tag,
  output logic                     Q_hit,
  output logic [DATA_W-1:0]        Q_data,
  output logic [3:0]               Q_stage,
  output logic [STAGES-1:0]        Tap_valid,
  output logic [STAGES*DATA_W-1:0] Tap_data,
  output logic [4:0]               Count
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned LAST  = STAGES - 1;

  logic [STAGES-1:0] valid_q;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic              wen_q  [STAGES];
  logic [CNT_W-1:0]  count_q;

  logic [STAGES-1:0] mv;
  logic              accept;
  logic              out_xfer;

  // A slot may move when any slot at or beyond it is empty, or the consumer takes the head.
  always_comb begin
    logic acc;
    acc = Out_ready;
    mv  = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      acc   = acc | ~valid_q[i];
      mv[i] = acc;
    end
  end

  assign In_ready  = mv[0] & ~Flush & ~Clr;
  assign accept    = In_valid & In_ready;
  assign Out_valid = valid_q[LAST] & ~Flush;
  assign out_xfer  = Out_valid & Out_ready;
  assign Out_data  = data_q[LAST];
  assign Out_tag   = tag_q[LAST];
  assign Out_wen   = wen_q[LAST];
  assign Count     = count_q;
  assign Tap_valid = valid_q;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
        wen_q[i]  <= 1'b0;
      end
    end else if (Flush) begin
      // Payload registers intentionally keep their stale contents.
      valid_q <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(accept) - CNT_W'(out_xfer);
      if (mv[0]) begin
        valid_q[0] <= accept;
        if (accept) begin
          data_q[0] <= In_data;
          tag_q[0]  <= In_tag;
          wen_q[0]  <= In_wen;
        end
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        if (mv[i]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) begin
            data_q[i] <= data_q[i-1];
            tag_q[i]  <= tag_q[i-1];
            wen_q[i]  <= wen_q[i-1];
          end
        end
      end
    end
  end

  // Scan oldest to youngest so the lowest matching index is the one left standing.
  always_comb begin
    Q_hit   = 1'b0;
    Q_data  = '0;
    Q_stage = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      if (valid_q[i] && wen_q[i] && (tag_q[i] == Q_tag) && (Q_tag != '0)) begin
        Q_hit   = 1'b1;
        Q_data  = data_q[i];
        Q_stage = 4'(i);
      end
    end
  end

  always_comb begin
    Tap_data = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      Tap_data[i*DATA_W +: DATA_W] = data_q[i];
    end
  end

endmodule
